vx_fp_bf16_round_pack: RTL

Two-stage pipelined rounding and packing stage for the BF16 floating-point path. It sits directly downstream of the BF16 square-root core. Per lane, it takes an unrounded sign/exponent/significand with guard, round and sticky bits plus special-case class flags. It produces the final 16-bit BF16 encoding and the RISC-V fflags. It applies the requested rounding mode, handles subnormal denormalization, mantissa carry-out and overflow saturation, and carries a tag through a stall-on-backpressure valid/ready pipeline.

---
 rtl/vx_fp_bf16_round_pack_if.sv | 42 ++++
 rtl/vx_fp_bf16_round_pack.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vx_fp_bf16_round_pack_if.sv
// Handshake and per-lane operand/result bundle for the BF16 round/pack stage.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; ready_in is driven by the slave.
interface vx_fp_bf16_round_pack_if #(
    parameter int TAGW  = 1,
    parameter int LANES = 1
);
    // upstream side
    logic                        valid_in;
    logic                        ready_in;
    logic [TAGW-1:0]             tag_in;
    logic [2:0]                  frm;
    logic [LANES-1:0]            sign_in;
    logic [LANES-1:0][9:0]       exp_in;
    logic [LANES-1:0][9:0]       sig_in;
    logic [LANES-1:0]            sticky_in;
    logic [LANES-1:0]            is_nan_in;
    logic [LANES-1:0]            is_inf_in;
    logic [LANES-1:0]            is_zero_in;
    logic [LANES-1:0]            nv_in;
    logic [LANES-1:0]            dz_in;

    // downstream side; fflags per lane is {NV, DZ, OF, UF, NX}
    logic [LANES-1:0][15:0]      result;
    logic                        has_fflags;
    logic [LANES-1:0][4:0]       fflags;
    logic [TAGW-1:0]             tag_out;
    logic                        valid_out;
    logic                        ready_out;

    modport master (
        output valid_in, tag_in, frm, sign_in, exp_in, sig_in, sticky_in,
               is_nan_in, is_inf_in, is_zero_in, nv_in, dz_in, ready_out,
        input  ready_in, result, has_fflags, fflags, tag_out, valid_out
    );

    modport slave (
        input  valid_in, tag_in, frm, sign_in, exp_in, sig_in, sticky_in,
               is_nan_in, is_inf_in, is_zero_in, nv_in, dz_in, ready_out,
        output ready_in, result, has_fflags, fflags, tag_out, valid_out
    );
endinterface

// File: rtl/vx_fp_bf16_round_pack.sv
// Rounds and packs an unrounded BF16 sign/exponent/significand per lane, producing result + fflags.
// Latency: 2 cycles (stage 1: denormalize + increment decision, stage 2: add, renormalize, pack).
// Backpressure: whole-pipe stall while valid_out & ~ready_out; ready_in low during the stall.
module vx_fp_bf16_round_pack #(
    parameter int TAGW  = 1,
    parameter int LANES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    vx_fp_bf16_round_pack_if.slave   bus
);

    // Stage-1 per-lane state: everything stage 2 needs to finish the rounding.
    typedef struct packed {
        logic       sign;
        logic       nan;
        logic       inf;
        logic       zero;
        logic       nv;
        logic       dz;
        logic       subn;     // pre-rounding value was subnormal
        logic [9:0] expo;     // working exponent, 0 for subnormals, else positive
        logic [7:0] man;      // {hidden, mant[6:0]} after denormalizing
        logic       inc;      // round-up decision
        logic       inexact;
    } s1_lane_t;

    s1_lane_t               s1_d [LANES];
    s1_lane_t               s1_q [LANES];
    logic                   s1_vld;
    logic [2:0]             s1_frm;
    logic [TAGW-1:0]        s1_tag;
    logic                   s2_vld;

    logic [15:0]            res_d [LANES];
    logic [4:0]             flg_d [LANES];

    logic                   stall;
    logic                   enable;

    assign stall          = s2_vld & ~bus.ready_out;
    assign enable         = ~stall;
    assign bus.ready_in   = enable;
    assign bus.valid_out  = s2_vld;
    assign bus.has_fflags = 1'b1;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [10:0] x;
        logic [10:0] xs;
        logic [10:0] t;
        logic [3:0]  shamt;
        logic        subn;
        logic        lost;
        logic [9:0]  sig;
        logic        stk;
        logic        g;
        logic        r;
        logic        inx;
        logic        inc;

        // Stage 1: denormalize subnormals (shift right by 1-exp, capped) and pick the increment.
        always_comb begin
            x     = {bus.sig_in[l], bus.sticky_in[l]};
            subn  = bus.exp_in[l][9] | (bus.exp_in[l] == 10'd0);
            t     = 11'd1 - {bus.exp_in[l][9], bus.exp_in[l]};
            shamt = 4'd0;
            if (subn) begin
                shamt = (t > 11'd11) ? 4'd11 : t[3:0];
            end
            xs    = x >> shamt;
            lost  = |(x & ~(11'h7FF << shamt));
            sig   = xs[10:1];
            stk   = xs[0] | lost;
            g     = sig[1];
            r     = sig[0] | stk;
            inx   = g | r;
            case (bus.frm)
                3'b001:  inc = 1'b0;                       // RTZ
                3'b010:  inc = bus.sign_in[l] & inx;       // RDN
                3'b011:  inc = ~bus.sign_in[l] & inx;      // RUP
                3'b100:  inc = g;                          // RMM
                default: inc = g & (r | sig[2]);           // RNE and reserved encodings
            endcase
            s1_d[l] = '{
                sign:    bus.sign_in[l],
                nan:     bus.is_nan_in[l],
                inf:     bus.is_inf_in[l],
                zero:    bus.is_zero_in[l],
                nv:      bus.nv_in[l],
                dz:      bus.dz_in[l],
                subn:    subn,
                expo:    subn ? 10'd0 : bus.exp_in[l],
                man:     sig[9:2],
                inc:     inc,
                inexact: inx
            };
        end

        s1_lane_t    cur;
        logic [8:0]  sum;
        logic [10:0] exp_r;
        logic [6:0]  mant;
        logic        ovf;
        logic        to_inf;

        // Stage 2: apply increment, renormalize, saturate on overflow, then let specials override.
        always_comb begin
            cur   = s1_q[l];
            sum   = {1'b0, cur.man} + {8'd0, cur.inc};
            exp_r = {1'b0, cur.expo} + {10'd0, sum[8]};
            mant  = sum[8] ? 7'd0 : sum[6:0];
            // a subnormal that rounds up into the hidden bit becomes the smallest normal
            if (cur.subn && sum[7]) begin
                exp_r = 11'd1;
            end
            ovf = (exp_r >= 11'd255);
            case (s1_frm)
                3'b001:  to_inf = 1'b0;
                3'b010:  to_inf = cur.sign;
                3'b011:  to_inf = ~cur.sign;
                default: to_inf = 1'b1;
            endcase
            res_d[l] = {cur.sign, exp_r[7:0], mant};
            flg_d[l] = {2'b00, 1'b0, cur.subn & cur.inexact, cur.inexact};
            if (ovf) begin
                res_d[l] = {cur.sign, to_inf ? 15'h7F80 : 15'h7F7F};
                flg_d[l] = {2'b00, 1'b1, cur.subn & cur.inexact, 1'b1};
            end
            if (cur.zero) begin
                res_d[l] = {cur.sign, 15'h0000};
                flg_d[l] = 5'b00000;
            end
            if (cur.inf) begin
                res_d[l] = {cur.sign, 8'hFF, 7'h00};
                flg_d[l] = {cur.nv, cur.dz, 3'b000};
            end
            if (cur.nan) begin
                res_d[l] = 16'h7FC0;
                flg_d[l] = {cur.nv, cur.dz, 3'b000};
            end
        end
    end

    // Stage-1 registers: capture accepted operation with its rounding mode and tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
        end else if (enable) begin
            s1_vld <= bus.valid_in;
            if (bus.valid_in) begin
                s1_q   <= s1_d;
                s1_frm <= bus.frm;
                s1_tag <= bus.tag_in;
            end
        end
    end

    // Stage-2 registers: the output holding register, frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld      <= 1'b0;
            bus.result  <= '0;
            bus.fflags  <= '0;
            bus.tag_out <= '0;
        end else if (enable) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                for (int l = 0; l < LANES; l++) begin
                    bus.result[l] <= res_d[l];
                    bus.fflags[l] <= flg_d[l];
                end
                bus.tag_out <= s1_tag;
            end
        end
    end

endmodule
